// File: rtl/svnet_fifo_upsizer.sv
// Packs RATIO narrow words popped from an upstream FIFO into one wide word written downstream.
// Lane 0 lands in the LSBs; a flush pulse emits a partial word with its valid-lane count.
module svnet_fifo_upsizer #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned RATIO     = 4,
  parameter int unsigned IN_DEPTH  = 1,
  parameter int unsigned OUT_DEPTH = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [$clog2(IN_DEPTH):0]     i_in_used_space,
  input  logic [IN_WIDTH-1:0]           i_in_read_data,
  output logic                          o_in_read,
  input  logic [$clog2(OUT_DEPTH):0]    i_out_free_space,
  output logic                          o_out_write,
  output logic [IN_WIDTH*RATIO-1:0]     o_out_write_data,
  output logic [$clog2(RATIO):0]        o_out_write_count,
  input  logic                          i_flush,
  output logic                          o_busy
);

  localparam int unsigned CntW = $clog2(RATIO) + 1;
  localparam int unsigned IdxW = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [RATIO-1:0][IN_WIDTH-1:0] r_acc;
  logic [CntW-1:0]                r_cnt;
  logic                           r_flush_pending;

  logic                           w_full;
  logic                           w_emit;
  logic                           w_read;
  logic [CntW-1:0]                w_base;
  logic [IdxW-1:0]                w_idx;
  logic [RATIO-1:0][IN_WIDTH-1:0] w_data;

  assign w_full = (r_cnt == CntW'(RATIO));
  assign w_emit = rst_n && (w_full || (r_flush_pending && (r_cnt != '0)))
                  && (i_out_free_space != '0);
  // Reading while full is allowed only when the emit frees the slot in the same cycle.
  assign w_read = rst_n && (i_in_used_space != '0) && !r_flush_pending
                  && (!w_full || w_emit);
  assign w_base = w_emit ? '0 : r_cnt;
  assign w_idx  = w_base[IdxW-1:0];

  always_comb begin
    w_data = '0;
    for (int k = 0; k < int'(RATIO); k++) begin
      if (CntW'(k) < r_cnt) w_data[k] = r_acc[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc           <= '0;
      r_cnt           <= '0;
      r_flush_pending <= 1'b0;
    end else begin
      if (w_emit) r_acc <= '0;
      if (w_read) r_acc[w_idx] <= i_in_read_data;
      r_cnt <= w_read ? (w_base + CntW'(1)) : w_base;
      // Pulses seen while a flush is already pending are absorbed.
      if (r_flush_pending) r_flush_pending <= !(w_emit || (r_cnt == '0));
      else                 r_flush_pending <= i_flush;
    end
  end

  assign o_in_read         = w_read;
  assign o_out_write       = w_emit;
  assign o_out_write_data  = w_data;
  assign o_out_write_count = r_cnt;
  assign o_busy            = (r_cnt != '0) || r_flush_pending;

endmodule

// File: tb/tb_svnet_fifo_upsizer.sv
// Self-checking bench for svnet_fifo_upsizer: directed scenarios plus a randomized stall/flush
// run whose downstream lane stream is compared against the upstream word sequence.
module tb_svnet_fifo_upsizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  i_in_used_space;
  logic [7:0]  i_in_read_data;
  logic        o_in_read;
  logic [2:0]  i_out_free_space;
  logic        o_out_write;
  logic [31:0] o_out_write_data;
  logic [2:0]  o_out_write_count;
  logic        i_flush;
  logic        o_busy;

  always #5 clk = ~clk;

  svnet_fifo_upsizer #(
    .IN_WIDTH (8),
    .RATIO    (4),
    .IN_DEPTH (4),
    .OUT_DEPTH(4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_in_used_space  (i_in_used_space),
    .i_in_read_data   (i_in_read_data),
    .o_in_read        (o_in_read),
    .i_out_free_space (i_out_free_space),
    .o_out_write      (o_out_write),
    .o_out_write_data (o_out_write_data),
    .o_out_write_count(o_out_write_count),
    .i_flush          (i_flush),
    .o_busy           (o_busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0]  up_q[$];
  bit          up_stall;
  int unsigned dn_free;

  logic        s_read, s_write, s_busy;
  logic [31:0] s_data;
  logic [2:0]  s_count, s_used, s_free;
  logic [7:0]  s_popped;

  // One clock: drive upstream/downstream from the models, sample mid-cycle, pop on read.
  task automatic cycle();
    int unsigned n;
    n = up_q.size();
    i_in_used_space  = up_stall ? 3'd0 : 3'((n > 4) ? 4 : n);
    i_in_read_data   = (n != 0) ? up_q[0] : 8'h00;
    i_out_free_space = 3'(dn_free);
    #1;
    s_read   = o_in_read;
    s_write  = o_out_write;
    s_data   = o_out_write_data;
    s_count  = o_out_write_count;
    s_busy   = o_busy;
    s_used   = i_in_used_space;
    s_free   = i_out_free_space;
    s_popped = i_in_read_data;
    if (s_read && n != 0) void'(up_q.pop_front());
    @(negedge clk);
    i_flush = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    up_q.delete();
    up_stall = 1'b0;
    dn_free  = 4;
    i_flush  = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    up_stall = 1'b0;
    dn_free = 4;
    up_q.push_back(8'h5A);
    cycle();
    cycle();
    n_checks++; if (s_read !== 1'b0) begin n_fail++; $display("FAIL reset_in_read: got %b want 0", s_read); end
    n_checks++; if (s_write !== 1'b0) begin n_fail++; $display("FAIL reset_out_write: got %b want 0", s_write); end
    n_checks++; if (s_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", s_data); end
    n_checks++; if (s_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", s_count); end
    n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", s_busy); end
    up_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    int b;
    do_reset();
    for (int k = 1; k <= 12; k++) up_q.push_back(8'(k * 17));
    for (int c = 0; c < 13; c++) begin
      cycle();
      n_checks++;
      if (s_read !== (c < 12)) begin n_fail++; $display("FAIL b2b_read c%0d: got %b want %b", c, s_read, (c < 12)); end
      n_checks++;
      if (s_write !== (c == 4 || c == 8 || c == 12)) begin
        n_fail++; $display("FAIL b2b_write c%0d: got %b", c, s_write);
      end
      if (c == 4 || c == 8 || c == 12) begin
        b = (c / 4 - 1) * 4;
        for (int j = 0; j < 4; j++) e[j*8 +: 8] = 8'((b + j + 1) * 17);
        n_checks++; if (s_data !== e) begin n_fail++; $display("FAIL b2b_data c%0d: got %h want %h", c, s_data, e); end
        n_checks++; if (s_count !== 3'd4) begin n_fail++; $display("FAIL b2b_count c%0d: got %0d want 4", c, s_count); end
      end
      if (c == 4) begin
        n_checks++; if (s_popped !== 8'h55) begin n_fail++; $display("FAIL b2b_pop_in_emit: got %h want 55", s_popped); end
      end
    end
    cycle();
    n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy: got %b want 0", s_busy); end
  endtask

  task automatic test_flush_partial();
    do_reset();
    up_q.push_back(8'hAA);
    up_q.push_back(8'hBB);
    cycle();
    cycle();
    up_q.push_back(8'h01);
    up_q.push_back(8'h02);
    up_stall = 1'b1;
    i_flush = 1'b1;
    cycle();
    n_checks++; if (s_write !== 1'b0) begin n_fail++; $display("FAIL flush_early_write: got %b want 0", s_write); end
    up_stall = 1'b0;
    cycle();
    n_checks++; if (s_write !== 1'b1) begin n_fail++; $display("FAIL flush_write: got %b want 1", s_write); end
    n_checks++; if (s_data !== 32'h0000BBAA) begin n_fail++; $display("FAIL flush_data: got %h want 0000bbaa", s_data); end
    n_checks++; if (s_count !== 3'd2) begin n_fail++; $display("FAIL flush_count: got %0d want 2", s_count); end
    n_checks++; if (s_read !== 1'b0) begin n_fail++; $display("FAIL flush_read_pending: got %b want 0", s_read); end
    cycle();
    n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after: got %b want 0", s_busy); end
    n_checks++; if (s_read !== 1'b1) begin n_fail++; $display("FAIL flush_read_resume: got %b want 1", s_read); end
  endtask

  task automatic test_flush_same_cycle();
    do_reset();
    up_q.push_back(8'h10);
    up_q.push_back(8'h20);
    up_q.push_back(8'h30);
    cycle();
    i_flush = 1'b1;
    cycle();
    n_checks++; if (s_read !== 1'b1) begin n_fail++; $display("FAIL fsame_read: got %b want 1", s_read); end
    cycle();
    n_checks++; if (s_write !== 1'b1) begin n_fail++; $display("FAIL fsame_write: got %b want 1", s_write); end
    n_checks++; if (s_data !== 32'h00002010) begin n_fail++; $display("FAIL fsame_data: got %h want 00002010", s_data); end
    n_checks++; if (s_count !== 3'd2) begin n_fail++; $display("FAIL fsame_count: got %0d want 2", s_count); end
  endtask

  task automatic test_flush_empty();
    do_reset();
    i_flush = 1'b1;
    cycle();
    n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL fempty_busy0: got %b want 0", s_busy); end
    cycle();
    n_checks++; if (s_busy !== 1'b1) begin n_fail++; $display("FAIL fempty_busy1: got %b want 1", s_busy); end
    n_checks++; if (s_write !== 1'b0) begin n_fail++; $display("FAIL fempty_write1: got %b want 0", s_write); end
    cycle();
    n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL fempty_busy2: got %b want 0", s_busy); end
    n_checks++; if (s_write !== 1'b0) begin n_fail++; $display("FAIL fempty_write2: got %b want 0", s_write); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 1; k <= 5; k++) up_q.push_back(8'(k * 17));
    dn_free = 0;
    for (int c = 0; c < 14; c++) begin
      cycle();
      n_checks++; if (s_write !== 1'b0) begin n_fail++; $display("FAIL bp_write c%0d: got %b want 0", c, s_write); end
      n_checks++; if (s_read !== (c < 4)) begin n_fail++; $display("FAIL bp_read c%0d: got %b want %b", c, s_read, (c < 4)); end
    end
    n_checks++; if (s_busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy: got %b want 1", s_busy); end
    dn_free = 4;
    cycle();
    n_checks++; if (s_write !== 1'b1) begin n_fail++; $display("FAIL bp_release_write: got %b want 1", s_write); end
    n_checks++; if (s_data !== 32'h44332211) begin n_fail++; $display("FAIL bp_release_data: got %h want 44332211", s_data); end
    n_checks++; if (s_count !== 3'd4) begin n_fail++; $display("FAIL bp_release_count: got %0d want 4", s_count); end
    n_checks++; if (s_read !== 1'b1 || s_popped !== 8'h55) begin
      n_fail++; $display("FAIL bp_release_pop: read %b data %h want 1/55", s_read, s_popped);
    end
  endtask

  task automatic test_reset_mid();
    int nw;
    do_reset();
    up_q.push_back(8'hE1);
    up_q.push_back(8'hE2);
    up_q.push_back(8'hE3);
    cycle(); cycle(); cycle();
    up_q.push_back(8'hE4);
    rst_n = 1'b0;
    cycle();
    n_checks++; if (s_read !== 1'b0) begin n_fail++; $display("FAIL rmid_read_in_reset: got %b want 0", s_read); end
    n_checks++; if (s_write !== 1'b0) begin n_fail++; $display("FAIL rmid_write_in_reset: got %b want 0", s_write); end
    up_q.delete();
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) up_q.push_back(8'(k));
    nw = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (s_write) begin
        nw++;
        n_checks++; if (s_data !== 32'h04030201) begin n_fail++; $display("FAIL rmid_data: got %h want 04030201", s_data); end
        n_checks++; if (s_count !== 3'd4) begin n_fail++; $display("FAIL rmid_count: got %0d want 4", s_count); end
      end
    end
    n_checks++; if (nw != 1) begin n_fail++; $display("FAIL rmid_writes: got %0d want 1", nw); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] w, lane;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      w = 8'($urandom);
      up_q.push_back(w);
      exp_q.push_back(w);
    end
    for (int cyc = 0; cyc < 60000 && exp_q.size() != 0; cyc++) begin
      up_stall = ($urandom_range(0, 9) < 3);
      dn_free  = ($urandom_range(0, 9) < 3) ? 0 : $urandom_range(1, 4);
      i_flush  = ($urandom_range(0, 99) == 0) || (up_q.size() == 0);
      cycle();
      n_checks++; if (s_read && s_used == 3'd0) begin n_fail++; $display("FAIL rnd_read_empty c%0d", cyc); end
      n_checks++; if (s_write && s_free == 3'd0) begin n_fail++; $display("FAIL rnd_write_full c%0d", cyc); end
      if (s_write) begin
        n_checks++;
        if (s_count < 3'd1 || s_count > 3'd4) begin n_fail++; $display("FAIL rnd_count: got %0d want 1..4", s_count); end
        for (int k = 0; k < 4; k++) begin
          lane = s_data[k*8 +: 8];
          n_checks++;
          if (k < int'(s_count)) begin
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL rnd_extra_lane: got %h want none", lane);
            end else begin
              w = exp_q.pop_front();
              if (lane !== w) begin n_fail++; $display("FAIL rnd_lane%0d: got %h want %h", k, lane, w); end
            end
          end else if (lane !== 8'h00) begin
            n_fail++; $display("FAIL rnd_pad_lane%0d: got %h want 00", k, lane);
          end
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_timeout: got %0d words left want 0", exp_q.size()); end
    up_stall = 1'b0;
    dn_free = 4;
    cycle(); cycle(); cycle();
    n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL rnd_end_busy: got %b want 0", s_busy); end
    n_checks++; if (up_q.size() != 0) begin n_fail++; $display("FAIL rnd_upstream_left: got %0d want 0", up_q.size()); end
  endtask

  initial begin
    rst_n = 1'b0;
    i_flush = 1'b0;
    up_stall = 1'b0;
    dn_free = 4;
    i_in_used_space = '0;
    i_in_read_data = '0;
    i_out_free_space = '0;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_flush_partial();
    test_flush_same_cycle();
    test_flush_empty();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/svnet_fifo_upsizer.md
# svnet_fifo_upsizer

Width-converting stage that sits directly downstream of a `svnet_reg_fifo` read port and upstream of another `svnet_reg_fifo` write port. It pops RATIO narrow words of IN_WIDTH bits and packs them into one wide word of IN_WIDTH*RATIO bits. Words are placed lane 0 first, in the LSBs. A flush request emits a partially filled word together with its valid-lane count. Feature-map streams use it to widen pixel or channel words in front of wide MAC arrays.

## Interface
- IN_WIDTH, default 8: narrow word width in bits.
- RATIO, default 4, legal range ≥2: narrow words per wide word.
- IN_DEPTH, default 1: depth of the upstream FIFO; sets the width of in_used_space.
- OUT_DEPTH, default 1: depth of the downstream FIFO; sets the width of out_free_space.
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_used_space  input  $clog2(IN_DEPTH)+1  upstream occupancy.
- in_read_data  input  IN_WIDTH  upstream head word; valid whenever in_used_space≠0.
- in_read  output  1  pops the upstream head this cycle.
- out_free_space  input  $clog2(OUT_DEPTH)+1  downstream free slots.
- out_write  output  1  writes out_write_data downstream this cycle.
- out_write_data  output  IN_WIDTH*RATIO  packed word; lane k is bits [k*IN_WIDTH +: IN_WIDTH].
- out_write_count  output  $clog2(RATIO)+1  number of valid lanes (1..RATIO), meaningful only with out_write.
- flush  input  1  single-cycle pulse; emit the current partial word.
- busy  output  1  cnt≠0 or a flush is pending.

## Operation
- State registers:
  - acc[RATIO-1:0][IN_WIDTH-1:0]
  - cnt, 0..RATIO
  - flush_pending
- emit = (cnt==RATIO || (flush_pending && cnt≠0)) && out_free_space≠0. This signal is combinational from registered state.
- out_write = emit. out_write_data = acc with lanes ≥cnt forced to zero. out_write_count = cnt.
- in_read = in_used_space≠0 && !flush_pending && (cnt<RATIO || emit).
- The upstream read path has zero read-to-valid delay: in_read_data is sampled in the same cycle in_read is asserted.
- Next-state rules:
  - base = emit ? 0 : cnt.
  - On in_read: acc[base] ← in_read_data, and cnt ← base+1.
  - Otherwise: cnt ← base.
  - On emit, lanes other than the newly written one are cleared to 0.
- Flush handling:
  - flush sets flush_pending at the next edge.
  - A word read in the same cycle as the flush pulse belongs to the flushed word.
  - flush_pending clears when emit fires, or immediately if cnt==0; in the cnt==0 case no write occurs.
  - A flush arriving while flush_pending is already 1 is absorbed.
- Full word plus pending flush: emits once with out_write_count=RATIO.
- Downstream full (out_free_space==0): the word is held, in_read stays low once cnt==RATIO, and no data is lost.
- Upstream empty: cnt holds and no output is produced unless a flush is pending.
- Assertions:
  - in_read implies in_used_space≠0.
  - out_write implies out_free_space≠0.
  - At end of simulation with rst_n high: cnt==0 and flush_pending==0.

## Timing
- Reset, while rst_n is low at a clock edge: acc=0, cnt=0, flush_pending=0.
- While rst_n is low, in_read and out_write are forced to 0.
- Reset values of the outputs: in_read=0, out_write=0, out_write_data=0, out_write_count=0, busy=0.
- Reset mid-word discards the partial word without emitting it.
- Latency: if the RATIO-th narrow word is popped at cycle t, out_write is asserted at t+1 when out_free_space≠0. With the downstream W2R delay of 1, the word is visible in downstream used_space at t+2.
- Throughput: one narrow word per cycle sustained. A word is read in the same cycle as the emit, so there is no bubble and a full wide word is produced every RATIO cycles.
- Flush latency: pulse at t, partial word written at t+1 at the earliest.

## Test plan
- RATIO=4, IN_WIDTH=8; upstream supplies 0x11,0x22,0x33,0x44,0x55… back-to-back → out_write_data 0x44332211 with count 4 one cycle after the fourth pop. 0x55 is popped in that same emit cycle, and the next word follows 4 cycles later.
- Two words 0xAA,0xBB, then flush → 0x0000BBAA with count 2. No in_read occurs while the flush is pending, and busy falls to 0 after the write.
- Flush with cnt==0 → no out_write, flush_pending clears after one cycle, busy returns to 0.
- out_free_space=0 held for 10 cycles with a full word pending → out_write=0, in_read=0 after the 4th word. Releasing free space emits the word next cycle with data intact.
- rst_n low after 3 words, then 4 new words 0x01..0x04 → single write 0x04030201. The discarded partial word never appears.
- Random in_used_space/out_free_space stall patterns over 10k words → downstream sequence equals the upstream sequence, and the both-sides-nonzero assertions never fire.
